// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
//
// Game-flow controller. Sequences MENU -> PLAY -> WON/LOST -> MENU from the
// start button, the collision flag and the elapsed game time reported by the
// shape/position counter. It drives that counter's level-control inputs and
// keeps a per-level score of completed obstacle passes.
//
// Ports
//   clk                  in   game-tick clock, shared with the counter
//   reset                in   synchronous, active-low reset
//   start_btn            in   start/continue button (level, synchronised)
//   collision            in   player/obstacle overlap flag (level)
//   obj_position_counter in   obstacle position 0,10,...,690 then wraps
//   game_time            in   elapsed PLAY ticks (only [TIME_W-1:0] used)
//   menuScreen           out  high in MENU
//   playerWon            out  high in WON
//   playerLost           out  high in LOST
//   score                out  obstacle passes in the current/last level
//   state_o              out  encoded state: MENU=0 PLAY=1 WON=2 LOST=3
// -----------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int TIME_W      = 32,
    parameter int WIN_TIME    = 600,
    parameter int RESULT_HOLD = 180,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               collision,
    input  logic [9:0]         obj_position_counter,
    input  logic [1023:0]      game_time,
    output logic               menuScreen,
    output logic               playerWon,
    output logic               playerLost,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        ST_MENU = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } state_t;

    localparam int                  HOLD_W    = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);
    localparam logic [TIME_W-1:0]   WIN_LIM   = TIME_W'(WIN_TIME);
    localparam logic [SCORE_W-1:0]  SCORE_MAX = '1;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_menu;
    logic                 r_won;
    logic                 r_lost;
    logic                 w_menu_d;
    logic                 w_won_d;
    logic                 w_lost_d;
    logic                 r_start_q;
    logic [9:0]           r_pos_q;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [SCORE_W-1:0]   r_score;

    logic                 w_start_rise;
    logic                 w_wrap;
    logic                 w_win;
    logic                 w_in_result;

    // Upper game_time bits are carried by the counter but never compared.
    generate
        if (TIME_W < 1024) begin : g_time_hi
            logic w_unused_time_hi;
            assign w_unused_time_hi = ^game_time[1023:TIME_W];
        end
    endgenerate

    // A held button produces exactly one rise; start_q clears on reset, so a
    // button already held at reset release still counts once.
    assign w_start_rise = start_btn & ~r_start_q;
    // Counter wrapped back to 0 on the previous edge.
    assign w_wrap       = (obj_position_counter == 10'd0) && (r_pos_q != 10'd0);
    assign w_win        = (game_time[TIME_W-1:0] >= WIN_LIM);
    assign w_in_result  = (r_state == ST_WON) || (r_state == ST_LOST);

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_MENU: begin
                if (w_start_rise) w_next_state = ST_PLAY;
            end
            ST_PLAY: begin
                // Collision outranks a simultaneous win.
                if (collision)  w_next_state = ST_LOST;
                else if (w_win) w_next_state = ST_WON;
            end
            ST_WON, ST_LOST: begin
                if ((r_hold_cnt == HOLD_LAST) || w_start_rise) w_next_state = ST_MENU;
            end
            default: w_next_state = ST_MENU;
        endcase
    end

    // ---------------- output decode (registered below) ----------------
    always_comb begin
        w_menu_d = (w_next_state == ST_MENU);
        w_won_d  = (w_next_state == ST_WON);
        w_lost_d = (w_next_state == ST_LOST);
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge
        // values regardless of statement order.
        if (!reset) begin
            r_state <= ST_MENU;
            r_menu  <= 1'b1;
            r_won   <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_menu  <= w_menu_d;
            r_won   <= w_won_d;
            r_lost  <= w_lost_d;
        end
    end

    // ---------------- edge detect, hold timer, score ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_start_q  <= 1'b0;
            r_pos_q    <= '0;
            r_hold_cnt <= '0;
            r_score    <= '0;
        end else begin
            r_start_q <= start_btn;
            r_pos_q   <= obj_position_counter;

            // Outside WON/LOST the timer sits at 0, so it reads 0 on entry.
            if (w_in_result) r_hold_cnt <= r_hold_cnt + 1'b1;
            else             r_hold_cnt <= '0;

            // A wrap seen on the PLAY exit edge still counts.
            if ((r_state == ST_MENU) && (w_next_state == ST_PLAY))
                r_score <= '0;
            else if ((r_state == ST_PLAY) && w_wrap && (r_score != SCORE_MAX))
                r_score <= r_score + 1'b1;
        end
    end

    assign menuScreen = r_menu;
    assign playerWon  = r_won;
    assign playerLost = r_lost;
    assign score      = r_score;
    assign state_o    = r_state;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

    localparam int WIN_TIME    = 600;
    localparam int RESULT_HOLD = 180;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_btn;
    logic          collision;
    logic [9:0]    pos_in;
    logic [1023:0] game_time;

    logic          menu_a, won_a, lost_a;
    logic [7:0]    score_a;
    logic [1:0]    st_a;
    logic          menu_b, won_b, lost_b;
    logic [1:0]    score_b;
    logic [1:0]    st_b;

    always #5 clk = ~clk;

    game_state_ctrl #(.TIME_W(32), .WIN_TIME(WIN_TIME), .RESULT_HOLD(RESULT_HOLD), .SCORE_W(8)) dut_a (
        .clk(clk), .reset(reset), .start_btn(start_btn), .collision(collision),
        .obj_position_counter(pos_in), .game_time(game_time),
        .menuScreen(menu_a), .playerWon(won_a), .playerLost(lost_a),
        .score(score_a), .state_o(st_a)
    );

    // Narrow-score copy sharing the same stimulus: exercises saturation.
    game_state_ctrl #(.TIME_W(32), .WIN_TIME(WIN_TIME), .RESULT_HOLD(RESULT_HOLD), .SCORE_W(2)) dut_b (
        .clk(clk), .reset(reset), .start_btn(start_btn), .collision(collision),
        .obj_position_counter(pos_in), .game_time(game_time),
        .menuScreen(menu_b), .playerWon(won_b), .playerLost(lost_b),
        .score(score_b), .state_o(st_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game phase (0 menu,1 play,2 won,3 lost), wraps seen
    // this level, ticks spent in the result screen, plus the counter model.
    int m_st, m_score, m_hold, m_pos_q, m_gt, m_pos;
    bit m_start_q;

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check_eq({tag, ".menu"},    32'(menu_a),  32'(m_st == 0));
        check_eq({tag, ".won"},     32'(won_a),   32'(m_st == 2));
        check_eq({tag, ".lost"},    32'(lost_a),  32'(m_st == 3));
        check_eq({tag, ".state"},   32'(st_a),    32'(m_st));
        check_eq({tag, ".score"},   32'(score_a), 32'(sat(m_score, 255)));
        check_eq({tag, ".score_b"}, 32'(score_b), 32'(sat(m_score, 3)));
        check_eq({tag, ".state_b"}, 32'(st_b),    32'(m_st));
    endtask

    task automatic drive_counter();
        game_time       = '0;
        game_time[31:0] = 32'(m_gt);
        pos_in          = 10'(m_pos);
    endtask

    // One clock edge: model evaluates the rules on pre-edge inputs, then the
    // counter model advances only while the controller was in PLAY.
    task automatic tick();
        int n_st, n_score, n_hold;
        bit rise, wrap, play_pre;
        rise     = start_btn && !m_start_q;
        wrap     = (m_pos == 0) && (m_pos_q != 0);
        play_pre = (m_st == 1);
        n_st = m_st; n_score = m_score; n_hold = m_hold;
        if (!reset) begin
            n_st = 0; n_score = 0; n_hold = 0;
        end else begin
            case (m_st)
                0: if (rise) begin n_st = 1; n_score = 0; end
                1: begin
                    if (wrap) n_score = m_score + 1;
                    if (collision)              n_st = 3;
                    else if (m_gt >= WIN_TIME)  n_st = 2;
                    n_hold = 0;
                end
                default: begin
                    if (m_hold == RESULT_HOLD - 1 || rise) n_st = 0;
                    else n_hold = m_hold + 1;
                end
            endcase
        end
        m_start_q = reset ? start_btn : 1'b0;
        m_pos_q   = reset ? m_pos : 0;
        @(posedge clk);
        #1;
        m_st = n_st; m_score = n_score; m_hold = n_hold;
        if (play_pre) begin
            m_gt  = m_gt + 1;
            m_pos = (m_pos + 10) % 700;
        end else begin
            m_gt  = 0;
            m_pos = 0;
        end
        drive_counter();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, h, coll_at;
        bit done;
        reset = 1'b0; start_btn = 1'b0; collision = 1'b0;
        m_st = 0; m_score = 0; m_hold = 0; m_pos_q = 0; m_gt = 0; m_pos = 0; m_start_q = 0;
        drive_counter();
        @(negedge clk);

        // Reset held for three ticks.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("reset");
        end
        check_eq("reset_menu", 32'(menu_a), 32'd1);

        // Release, hold start for five ticks: one transition only.
        reset = 1'b1;
        start_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) check_eq("start_first_edge", 32'(st_a), 32'd1);
            check_all("start_held");
        end
        start_btn = 1'b0;

        // Win: count edges from PLAY entry until playerWon.
        k = 4; done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick(); k++;
            check_all("win_run");
            if (won_a === 1'b1) done = 1;
        end
        check_eq("win_latency", 32'(k), 32'(WIN_TIME + 1));

        h = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick(); h++;
            check_all("win_hold");
            if (menu_a === 1'b1) done = 1;
        end
        check_eq("win_hold_len", 32'(h), 32'(RESULT_HOLD));
        check_eq("win_score", 32'(score_a), 32'd8);
        check_eq("win_score_sat", 32'(score_b), 32'd3);

        // Re-enter PLAY: score clears; presses in PLAY are ignored.
        start_btn = 1'b1;
        tick();
        check_eq("reenter_score", 32'(score_a), 32'd0);
        check_eq("reenter_score_b", 32'(score_b), 32'd0);
        check_all("reenter");
        for (int i = 0; i < 50; i++) begin
            start_btn = 1'($urandom % 2);
            tick();
            check_all("play_press");
        end
        check_eq("press_ignored", 32'(st_a), 32'd1);
        start_btn = 1'b0;

        // Loss priority: collision on the tick game_time reaches WIN_TIME.
        for (int i = 0; i < 1000 && m_gt != WIN_TIME; i++) begin
            tick();
            check_all("to_win_time");
        end
        collision = 1'b1;
        tick();
        check_eq("prio_lost", 32'(lost_a), 32'd1);
        check_eq("prio_won", 32'(won_a), 32'd0);
        check_all("prio");

        // Early exit from LOST once hold_cnt reaches 20.
        for (int i = 0; i < 100 && !(m_st == 3 && m_hold == 20); i++) begin
            collision = 1'($urandom % 2);
            tick();
            check_all("lost_hold");
        end
        collision = 1'b0;
        start_btn = 1'b1;
        tick();
        check_eq("early_exit", 32'(menu_a), 32'd1);
        check_all("early_exit");

        // Randomised levels: random collision time and random button presses.
        for (int it = 0; it < 6; it++) begin
            start_btn = 1'b0;
            tick();
            start_btn = 1'b1;
            tick();
            check_all("rnd_start");
            coll_at = int'($urandom_range(1, 700));
            done = 0;
            for (int t = 0; t < 1200 && !done; t++) begin
                start_btn = ($urandom % 4) == 0;
                collision = (t >= coll_at) ? 1'($urandom % 2) : 1'b0;
                tick();
                check_all("rnd_run");
                if (m_st == 0) done = 1;
            end
            check_eq("rnd_return", 32'(st_a), 32'd0);
        end
        collision = 1'b0;

        // Reset in the middle of PLAY with score 4.
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int i = 0; i < 400 && m_score != 4; i++) begin
            tick();
            check_all("to_score4");
        end
        check_eq("mid_score", 32'(score_a), 32'd4);
        reset = 1'b0;
        tick();
        check_eq("mid_reset_menu", 32'(menu_a), 32'd1);
        check_eq("mid_reset_score", 32'(score_a), 32'd0);
        check_all("mid_reset");

        // Button already held when reset releases: one rise at the first edge.
        start_btn = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check_eq("held_rise", 32'(st_a), 32'd1);
        tick();
        check_all("held_after");
        start_btn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Game-flow controller producing the `menuScreen`, `playerWon` and `playerLost` level-control signals consumed by the shape/position counter. It also consumes that counter's `obj_position_counter` and `game_time` outputs. It runs on the same game-tick clock as the counter and sequences MENU → PLAY → WON/LOST → MENU from the start button, the collision flag and elapsed game time. It also keeps a per-level score of completed obstacle passes for the display logic.

## Interface
Parameters:
- `TIME_W`, 32: compared width of `game_time`; only bits `[TIME_W-1:0]` are used.
- `WIN_TIME`, 600: ticks of survival in PLAY required to win.
- `RESULT_HOLD`, 180: ticks WON/LOST is held before auto-return to MENU.
- `SCORE_W`, 8: score width.

Ports:
- `clk`  in  1  game-tick clock, shared with the counter.
- `reset`  in  1  synchronous, active-low reset.
- `start_btn`  in  1  start/continue button, level, already synchronised to `clk`.
- `collision`  in  1  player/obstacle overlap flag from the renderer, level.
- `obj_position_counter`  in  10  obstacle position from the counter: 0, 10, …, 690, then wraps.
- `game_time`  in  1024  elapsed PLAY ticks from the counter.
- `menuScreen`  out  1  high in MENU.
- `playerWon`  out  1  high in WON.
- `playerLost`  out  1  high in LOST.
- `score`  out  SCORE_W  obstacle passes in the current/last level.
- `state_o`  out  2  encoded state: MENU=0, PLAY=1, WON=2, LOST=3.

## Operation
- FSM states are MENU, PLAY, WON and LOST. All outputs are registered and update on the same edge as the state register.
- Start detect: `start_q` registers `start_btn`; `start_rise = start_btn & ~start_q`. A held button yields exactly one `start_rise`.
- MENU:
  - `start_rise` → PLAY.
  - `score` is cleared to 0 on this transition.
- PLAY. Transitions are evaluated in this priority order:
  1. `collision` = 1 → LOST.
  2. `game_time[TIME_W-1:0] >= WIN_TIME` → WON.
  3. Otherwise stay in PLAY.
  - `collision` and the win condition on the same tick → LOST (collision has priority).
  - `start_rise` is ignored in PLAY.
- WON/LOST:
  - On entry, `hold_cnt` loads 0, then increments by 1 every tick.
  - Return to MENU when `hold_cnt == RESULT_HOLD-1` or on `start_rise`, whichever comes first.
  - `collision` is ignored in these states.
- Score:
  - `pos_q` registers `obj_position_counter`.
  - In PLAY, a wrap (`obj_position_counter == 0 && pos_q != 0`) increments `score`.
  - `score` saturates at `2^SCORE_W-1`.
  - `score` holds its value in WON, LOST and MENU until the next MENU→PLAY transition.
- Outputs are one-hot over `menuScreen`/`playerWon`/`playerLost`. PLAY drives all three low, which lets the counter run.
- Counter interaction:
  - While any of the three level-control outputs is high, the counter holds `game_time` = 0 and position = 0.
  - PLAY therefore always starts from `game_time` = 0.

## Timing
- Reset (`reset` = 0 sampled at an edge):
  - state = MENU, `menuScreen` = 1, `playerWon` = 0, `playerLost` = 0.
  - `score` = 0, `state_o` = 0.
  - `start_q`, `pos_q`, `hold_cnt` = 0.
- Reset overrides everything. Reset asserted mid-PLAY or mid-hold returns to MENU at that edge.
- Because `start_q` resets to 0, a button already held when reset releases produces one `start_rise` on the first active edge.
- Latency, one edge for each event:
  - `start_rise` sampled at edge N → `menuScreen` low after edge N.
  - `collision` sampled at edge N → `playerLost` high after edge N.
- Win timing: `game_time` = `WIN_TIME` is first visible in the tick after `WIN_TIME` PLAY ticks. `playerWon` rises one edge later.
- Hold duration: exactly `RESULT_HOLD` ticks with the result output high, then `menuScreen` = 1.
- Score wrap is detected one tick after the counter wraps. The final wrap coinciding with the PLAY exit edge still counts.

## Test plan
- Reset/start: hold `reset` = 0 for 3 ticks → `menuScreen` = 1, `score` = 0. Release, pulse `start_btn` for 5 ticks → exactly one transition; `state_o` = 1 after the first edge.
- Win: model the counter, no collision, `WIN_TIME` = 600 → `playerWon` rises one edge after `game_time` = 600. It holds for 180 ticks, then `menuScreen` = 1 and `score` = 8 (600/70 wraps).
- Loss priority: assert `collision` on the same tick as `game_time` = `WIN_TIME` → `playerLost` = 1, `playerWon` stays 0.
- Early exit: in LOST, press `start_btn` at `hold_cnt` = 20 → MENU next edge. A press in PLAY is ignored.
- Saturation: `SCORE_W` = 2, 6 wraps in PLAY → `score` stops at 3. Entering PLAY again clears it to 0.
- Mid-operation reset: `reset` = 0 during PLAY with `score` = 4 → MENU, `score` = 0 after that edge.
